// File: rtl/prog_ram_loader.sv
// prog_ram_loader: loads a framed, XOR-checked program image into a 16x8 RAM and holds the CPU in reset until it is verified.
module prog_ram_loader #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RESETn,
    input  logic          LOAD_START,
    input  logic [DW-1:0] DIN,
    input  logic          DIN_VALID,
    output logic          DIN_READY,
    input  logic [AW-1:0] ABUS,
    input  logic          CE,
    output logic [DW-1:0] DBUS,
    output logic          CPU_RESETn,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR
);
    typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, FILL, RUN, ERROR} state_t;
    state_t state_q, state_d;
    logic [AW:0] addr_q, addr_d, n_q, n_d;
    logic [DW-1:0] acc_q, acc_d, wdata;
    logic din_ready_q, din_ready_d, busy_q, busy_d, done_q, done_d, err_q, err_d, cpu_resetn_q, cpu_resetn_d;
    logic xfer, we;
    logic [DW-1:0] mem [1<<AW];
    always_comb begin
        xfer = DIN_VALID && din_ready_q;
        state_d = state_q;
        addr_d = addr_q;
        n_d = n_q;
        acc_d = acc_q;
        case (state_q)
            IDLE, RUN, ERROR: if (LOAD_START) state_d = COUNT;
            COUNT: if (xfer) begin
                if (DIN >= DW'(1) && DIN <= DW'(1 << AW)) begin
                    n_d = DIN[AW:0];
                    addr_d = '0;
                    acc_d = '0;
                    state_d = DATA;
                end else state_d = ERROR;
            end
            DATA: if (xfer) begin
                addr_d = addr_q + 1'b1;
                acc_d = acc_q ^ DIN;
                if (addr_d == n_q) state_d = CHECK;
            end
            CHECK: if (xfer) begin
                addr_d = n_q;
                state_d = (DIN != acc_q) ? ERROR : n_q[AW] ? RUN : FILL;
            end
            FILL: begin
                addr_d = addr_q + 1'b1;
                if (&addr_q[AW-1:0]) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        // outputs are decoded from the next state so they settle with the state register
        din_ready_d = state_d inside {COUNT, DATA, CHECK};
        busy_d = state_d inside {COUNT, DATA, CHECK, FILL};
        done_d = state_d == RUN;
        err_d = state_d == ERROR;
        cpu_resetn_d = state_d == RUN;
        we = (state_q == DATA && xfer) || state_q == FILL;
        wdata = (state_q == FILL) ? '0 : DIN;
    end
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q <= IDLE;
            addr_q <= '0;
            n_q <= '0;
            acc_q <= '0;
            din_ready_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            cpu_resetn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            n_q <= n_d;
            acc_q <= acc_d;
            din_ready_q <= din_ready_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            cpu_resetn_q <= cpu_resetn_d;
        end
    end
    // RAM has no reset; a reset edge aborts any pending write
    always_ff @(posedge CLK) begin
        if (RESETn && we) mem[addr_q[AW-1:0]] <= wdata;
    end
    assign DBUS = CE ? '0 : mem[ABUS];
    assign DIN_READY = din_ready_q;
    assign BUSY = busy_q;
    assign DONE = done_q;
    assign ERR = err_q;
    assign CPU_RESETn = cpu_resetn_q;
endmodule

// File: doc/prog_ram_loader.md
# prog_ram_loader

Writer-side counterpart to the CPU's 16×8 program store. Receives a framed program image over a byte-wide valid/ready stream and writes it into an internal 16×8 RAM, which the CPU reads through the same ABUS/CE/DBUS interface the fetch path already uses. It holds the CPU in reset until a complete, checksum-verified image is loaded, and zero-fills unused locations.

## Interface
- AW, 4, address width; depth = 2^AW = 16
- DW, 8, data width
- CLK  in  1  system clock; all state updates on the rising edge
- RESETn  in  1  reset, synchronous, active-low
- LOAD_START  in  1  one-cycle pulse; begins a load frame
- DIN  in  DW  stream byte
- DIN_VALID  in  1  DIN holds a valid byte
- DIN_READY  out  1  loader accepts DIN this cycle
- ABUS  in  AW  CPU read address
- CE  in  1  CPU read enable, active-low
- DBUS  out  DW  read data: RAM[ABUS] when CE=0, else 8'h00 (combinational)
- CPU_RESETn  out  1  drive to CPU RESETn; 0 holds the CPU in reset
- BUSY  out  1  frame in progress (COUNT/DATA/CHECK/FILL)
- DONE  out  1  image loaded and verified
- ERR  out  1  last frame rejected

## Operation
- Frame: count byte N, then N data bytes, then one check byte. Valid N = 1..16.
- Check rule: check byte must equal the XOR of the N data bytes.
- Transfer occurs on an edge where DIN_VALID=1 and DIN_READY=1. DIN_READY=1 only in COUNT, DATA and CHECK; it is registered from state and does not depend on DIN_VALID.
- States:
  - IDLE: wait for LOAD_START, then go to COUNT.
  - COUNT: accept N. If N is 1..16, latch N, clear the address counter and XOR accumulator, and go to DATA. Otherwise go to ERROR.
  - DATA: each transfer writes DIN to RAM[addr], increments addr and XORs into the accumulator. After the Nth transfer, go to CHECK.
  - CHECK: accept the check byte. On mismatch go to ERROR. On match: if N=16 go to RUN, else go to FILL with addr=N.
  - FILL: write 8'h00 to RAM[addr] once per cycle, addr++. After writing address 15, go to RUN.
  - RUN: DONE=1, CPU_RESETn=1. LOAD_START goes to COUNT.
  - ERROR: ERR=1, CPU_RESETn=0. LOAD_START goes to COUNT.
- Entering COUNT clears DONE and ERR and drives CPU_RESETn=0 from the next cycle.
- LOAD_START is ignored while BUSY=1.
- Address counter is AW+1 bits wide, so 16 does not wrap to 0.
- RAM has a single write port and is never written outside DATA/FILL. DBUS may read RAM at any time; during a load the CPU is held in reset, so reads are don't-care.
- RAM contents are not cleared by reset.

## Timing
- Reset (RESETn=0 at an edge): state IDLE, DIN_READY=0, BUSY=0, DONE=0, ERR=0, CPU_RESETn=0, addr=0, accumulator=0. RAM is untouched.
- Reset mid-frame: abort to IDLE on that edge. Partially written RAM is left as is; DONE stays 0 until a new frame completes.
- LOAD_START at edge t: COUNT, BUSY=1 and DIN_READY=1 are visible after edge t.
- Check byte accepted at edge k:
  - N=16 and match: DONE=1, CPU_RESETn=1, BUSY=0 after edge k.
  - N<16 and match: 16−N FILL cycles, then DONE after edge k+16−N.
  - Mismatch: ERR=1 after edge k.
- Minimum frame length: N+2 transfer cycles. DIN_VALID gaps stall the frame without limit; there is no timeout.
- A DATA write at edge e is visible on DBUS (ABUS=addr, CE=0) after edge e.

## Test plan
- Reset: assert RESETn=0 for 2 cycles with DIN_VALID=1. Expect DIN_READY=0, BUSY=0, DONE=0, ERR=0, CPU_RESETn=0. LOAD_START while RESETn=0 has no effect.
- Nominal short load: LOAD_START, stream 0x03, 0x11, 0x22, 0x44, check 0x77. Expect RAM[0..2]=11/22/44 and RAM[3..15]=00. DONE and CPU_RESETn rise exactly 13 cycles after the check byte. ABUS=1, CE=0 gives DBUS=0x22; CE=1 gives 0x00.
- Full load with backpressure: N=0x10 with 16 bytes 0x00..0x0F, check 0x00, and DIN_VALID toggled randomly. Expect no byte lost or duplicated, and DONE on the edge after the check byte with no FILL. LOAD_START pulsed mid-frame is ignored.
- Bad checksum: N=2, bytes 0xA5, 0x5A, check 0x00. Expect ERR=1, DONE=0, CPU_RESETn=0. A following valid frame clears ERR and reaches DONE.
- Bad count: count byte 0x00 gives ERR after that edge with no RAM write. Repeat with 0x11, same result.
- Reset mid-load: after 2 of 5 data bytes, pulse RESETn=0. Expect IDLE, BUSY=0, CPU_RESETn=0. A new 5-byte frame loads correctly, and the reload from RUN lowers CPU_RESETn the cycle after LOAD_START.
